// File: rtl/loteria_pkg.sv
// ---------------------------------------------------------------------------
// loteria_pkg
// Shared definitions for the lottery draw block: BCD digit type, draw FSM
// states, LFSR feedback taps and active-low seven-segment patterns
// (bit order {g,f,e,d,c,b,a}, a lit segment is 0).
// ---------------------------------------------------------------------------
package loteria_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        GAP,
        PUBLISH,
        HOLD
    } draw_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_P    = 7'b0001100;
    localparam logic [6:0] SEG_S    = 7'b0010010;

    function automatic logic [6:0] seg7(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/loteria_lfsr16.sv
// ---------------------------------------------------------------------------
// loteria_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left with
// the feedback bit entering bit 0. Always enabled.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; loads seed (all-zero seed -> 16'h0001)
//   seed   reset load value
//   value  current register contents
// ---------------------------------------------------------------------------
module loteria_lfsr16
    import loteria_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] seed_eff;
    logic        feedback;

    // The all-zero state is a lock-up state for an XOR LFSR.
    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    assign feedback = ^(lfsr_q & LFSR_TAPS);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed_eff;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/loteria_sorteio.sv
// ---------------------------------------------------------------------------
// loteria_sorteio
// Draw side of the lottery game. On start, draws five BCD digits by rejection
// sampling the low nibble of a free-running LFSR, reveals them one at a time
// with REVEAL_TICKS cycles between an accepted digit and the next attempt,
// then publishes the full number over a valid/ack handshake.
//
// Build option: define LOTERIA_FIXED_DRAW_EN to draw the digits of FIXED_NUM
// instead of LFSR samples (timing and handshake unchanged).
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        begin a new draw (honoured only in IDLE or HOLD)
//   ack          consumer accepted draw_num (honoured only while valid)
//   draw_valid   draw_num complete and stable
//   draw_num     digit0 in [19:16] .. digit4 in [3:0]
//   busy         drawing or waiting between digits
//   LEDR         [4:0] revealed thermometer, [8] busy, [9] draw_valid
//   HEX4..HEX0   digit0..digit4, active-low, dash until revealed
//   HEX5         'S' while busy or valid, otherwise dash
// ---------------------------------------------------------------------------
module loteria_sorteio
    import loteria_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          REVEAL_TICKS = 50_000_000,
    parameter logic [19:0] FIXED_NUM    = 20'h50967
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    output logic        draw_valid,
    output logic [19:0] draw_num,
    output logic        busy,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    draw_state_t state_q, state_d;
    logic [2:0]  idx_q;
    bcd_t        digit_q [5];
    logic [4:0]  mask_q;
    logic [31:0] timer_q;
    logic [19:0] num_q;

    logic [15:0] lfsr_value;
    bcd_t        candidate;
    logic        cand_ok;
    logic        begin_draw;
    logic        accept;
    logic        unused_ok;

    loteria_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

`ifdef LOTERIA_FIXED_DRAW_EN
    always_comb begin
        case (idx_q)
            3'd0:    candidate = FIXED_NUM[19:16];
            3'd1:    candidate = FIXED_NUM[15:12];
            3'd2:    candidate = FIXED_NUM[11:8];
            3'd3:    candidate = FIXED_NUM[7:4];
            default: candidate = FIXED_NUM[3:0];
        endcase
    end
    // The LFSR keeps running so the timing matches the random build.
    assign unused_ok = ^lfsr_value;
`else
    assign candidate = lfsr_value[3:0];
    assign unused_ok = ^{lfsr_value[15:4], FIXED_NUM};
`endif

    // Nibbles 10..15 are rejected so the accepted digits stay uniform.
    assign cand_ok = (candidate <= 4'd9);

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        begin_draw = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    begin_draw = 1'b1;
                    state_d    = DRAW;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    accept  = 1'b1;
                    state_d = (idx_q == 3'd4) ? PUBLISH : GAP;
                end
            end
            GAP: begin
                if (timer_q == 32'd0) begin
                    state_d = DRAW;
                end
            end
            PUBLISH: begin
                if (ack) begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the five-entry digit array is cleared on reset on purpose: it is
    // a handful of flops, and a defined value keeps draw_num/HEX predictable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            mask_q  <= 5'b0;
            timer_q <= 32'd0;
            num_q   <= 20'h0;
            for (int i = 0; i < 5; i++) begin
                digit_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;

            if (begin_draw) begin
                idx_q  <= 3'd0;
                mask_q <= 5'b0;
            end

            if (accept) begin
                digit_q[idx_q] <= candidate;
                mask_q[idx_q]  <= 1'b1;
                if (idx_q != 3'd4) begin
                    idx_q   <= idx_q + 3'd1;
                    timer_q <= 32'(REVEAL_TICKS - 1);
                end else begin
                    // Latch the whole number at once so a partial draw is
                    // never visible on draw_num.
                    num_q <= {digit_q[0], digit_q[1], digit_q[2], digit_q[3], candidate};
                end
            end

            if (state_q == GAP && timer_q != 32'd0) begin
                timer_q <= timer_q - 32'd1;
            end
        end
    end

    assign draw_valid = (state_q == PUBLISH);
    assign busy       = (state_q == DRAW) || (state_q == GAP);
    assign draw_num   = num_q;
    assign LEDR       = {draw_valid, busy, 3'b000, mask_q};

    assign HEX4 = mask_q[0] ? seg7(digit_q[0]) : SEG_DASH;
    assign HEX3 = mask_q[1] ? seg7(digit_q[1]) : SEG_DASH;
    assign HEX2 = mask_q[2] ? seg7(digit_q[2]) : SEG_DASH;
    assign HEX1 = mask_q[3] ? seg7(digit_q[3]) : SEG_DASH;
    assign HEX0 = mask_q[4] ? seg7(digit_q[4]) : SEG_DASH;
    assign HEX5 = (busy || draw_valid) ? SEG_S : SEG_DASH;

endmodule

// File: tb/tb_loteria_sorteio.sv
// ---------------------------------------------------------------------------
// tb_loteria_sorteio
// Directed bench for loteria_sorteio with REVEAL_TICKS=4. A bench-side LFSR
// model predicts the cycle and value of every accepted digit when start is
// driven; predictions are queued and popped as the revealed mask grows.
// Honours LOTERIA_FIXED_DRAW_EN for the digit source.
// ---------------------------------------------------------------------------
module tb_loteria_sorteio;

    localparam int          T     = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [19:0] FIXED = 20'h50967;
    localparam logic [6:0]  DASH  = 7'b0111111;
    localparam logic [6:0]  S_SEG = 7'b0010010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        draw_valid;
    logic [19:0] draw_num;
    logic        busy;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    loteria_sorteio #(
        .LFSR_SEED    (SEED),
        .REVEAL_TICKS (T),
        .FIXED_NUM    (FIXED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ack        (ack),
        .draw_valid (draw_valid),
        .draw_num   (draw_num),
        .busy       (busy),
        .LEDR       (LEDR),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    // Reference LFSR: same reset value and per-cycle advance as the draw block.
    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

    typedef struct {
        int         cyc;
        int         idx;
        logic [3:0] val;
    } dig_t;

    dig_t        exp_q[$];
    logic [3:0]  exp_dig [5];
    logic [19:0] exp_num;
    int          s_cyc;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    function automatic logic [6:0] hex_of(input int i);
        case (i)
            0:       return HEX4;
            1:       return HEX3;
            2:       return HEX2;
            3:       return HEX1;
            default: return HEX0;
        endcase
    endfunction

    // Called on the negedge where start is raised; l0 is the LFSR value of
    // the cycle in which start is sampled. Digit i becomes visible one cycle
    // after the DRAW cycle that accepts it.
    task automatic predict(input logic [15:0] l0);
        logic [15:0] l;
        logic [19:0] fx;
        logic [3:0]  v;
        int          c;
        l  = lfsr_step(l0);
        fx = FIXED;
        c  = 1;
        s_cyc = cyc;
        for (int i = 0; i < 5; i++) begin
`ifdef LOTERIA_FIXED_DRAW_EN
            v = fx[19 - 4*i -: 4];
`else
            while (l[3:0] > 4'd9) begin
                l = lfsr_step(l);
                c++;
            end
            v = l[3:0];
`endif
            exp_q.push_back('{cyc: s_cyc + 1 + c, idx: i, val: v});
            exp_dig[i] = v;
            for (int k = 0; k <= T; k++) l = lfsr_step(l);
            c += T + 1;
        end
        exp_num = {exp_dig[0], exp_dig[1], exp_dig[2], exp_dig[3], exp_dig[4]};
    endtask

    task automatic begin_draw();
        start = 1'b1;
        predict(m_lfsr);
    endtask

    // Follows the reveal until `want` digits have appeared; `poke` (>0)
    // raises start for one cycle at that offset to show it is ignored.
    task automatic monitor(input int want, input int poke);
        logic [4:0] prev;
        logic [4:0] mask;
        dig_t       e;
        int         got;
        int         budget;
        prev = 5'b0;
        got = 0;
        budget = 0;
        while (got < want && exp_q.size() > 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
            start = (poke > 0 && cyc == s_cyc + poke);
            mask = LEDR[4:0];
            if (budget == 1) begin
                check("draw_busy", {busy, LEDR[8], HEX5}, {2'b11, S_SEG});
                check("draw_dashes", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{DASH}});
            end
            if (mask != prev || cyc == exp_q[0].cyc) begin
                e = exp_q.pop_front();
                check("dig_cycle", cyc, e.cyc);
                check("dig_therm", mask, (1 << (e.idx + 1)) - 1);
                check("dig_hex", hex_of(e.idx), seg(e.val));
                got++;
            end
            prev = mask;
        end
        start = 1'b0;
        check("dig_count", got, want);
    endtask

    task automatic check_published();
        check("pub_flags", {draw_valid, busy, HEX5}, {2'b10, S_SEG});
        check("pub_num", draw_num, exp_num);
        check("pub_ledr", LEDR, 10'h21F);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int bad;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{DASH}});
        check("rst_ledr", LEDR, 10'h000);
        check("rst_flags", {draw_valid, busy}, 2'b00);
        check("rst_num", draw_num, 20'h0);
        reset = 1'b0;

        // ack with nothing published does nothing.
        pulse_ack();
        check("ack_idle", {draw_valid, busy, LEDR}, 12'h000);
        repeat (6) @(negedge clk);

        // First draw, with a stray start while busy.
        begin_draw();
        monitor(5, 9);
        check_published();

        // Held in PUBLISH for 100 cycles; a start in the middle is ignored.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = (i == 50);
            if ({draw_valid, draw_num} !== {1'b1, exp_num}) bad++;
        end
        start = 1'b0;
        check("pub_stable", bad, 0);

        // ack -> HOLD, valid drops, number retained.
        pulse_ack();
        check("hold_flags", {draw_valid, busy, HEX5, LEDR}, {2'b00, DASH, 10'h01F});
        check("hold_display", {HEX4, HEX3, HEX2, HEX1, HEX0},
              {seg(exp_dig[0]), seg(exp_dig[1]), seg(exp_dig[2]), seg(exp_dig[3]), seg(exp_dig[4])});
        check("hold_num", draw_num, exp_num);
        repeat (3) @(negedge clk);
        check("hold_stays", {draw_valid, busy}, 2'b00);

        // start in HOLD: dashes again and a fresh draw.
        begin_draw();
        monitor(5, 0);
        check_published();
        pulse_ack();
        check("ack2_drop", draw_valid, 1'b0);

        // Reset after two digits: everything back to reset values.
        begin_draw();
        monitor(2, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ledr", LEDR, 10'h000);
        check("midrst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{DASH}});
        check("midrst_flags", {draw_valid, busy}, 2'b00);
        check("midrst_num", draw_num, 20'h0);
        reset = 1'b0;
        exp_q.delete();

        // Draw straight out of reset: depends on the LFSR restarting at the seed.
        begin_draw();
        monitor(5, 0);
        check_published();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/loteria_sorteio.md
Name: loteria_sorteio

Overview:
- Draw side of the lottery game. Generates the 5-digit winning number that the player-side checker compares bets against.
- On a start pulse, produces 5 BCD digits (0-9) from a free-running 16-bit LFSR using rejection sampling.
- Reveals the digits one at a time on seven-segment displays with a fixed gap, then publishes the full number over a valid/ack handshake.
- Sits beside the player-entry FSM on the same board. Uses the same active-low display encoding and LEDR progress style.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR load value on reset; a value of 0 is replaced by 16'h0001.
- REVEAL_TICKS, 50_000_000, clock cycles between one accepted digit and the next draw attempt (>=1).
- FIXED_NUM, 20'h50967, BCD number used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new draw; sampled only in IDLE or HOLD
- ack  in  1  consumer has accepted draw_num
- draw_valid  out  1  draw_num is complete and stable
- draw_num  out  20  BCD digits; digit0 (first drawn) in [19:16], digit4 in [3:0]
- busy  out  1  high in DRAW or GAP
- LEDR  out  10  progress: [4:0] revealed-digit thermometer, [8]=busy, [9]=draw_valid
- HEX4..HEX0  out  7 each  digit0..digit4, active-low; unrevealed digits show dash 7'b0111111
- HEX5  out  7  shows 'S' 7'b0010010 while busy or valid, otherwise dash

Behaviour:
- Clock, reset and sampling:
  - Single clock clk. Reset is synchronous, active-high, and checked at posedge clk with priority over all else.
- Reset values:
  - state=IDLE, idx=0, all digits=0, revealed mask=0, LFSR=LFSR_SEED (0 replaced by 1).
  - draw_valid=0, busy=0, draw_num=0, LEDR=0.
  - HEX0-HEX5=dash.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left with feedback into bit0.
  - Advances every cycle in every state, so entropy comes from the timing of start.
- IDLE:
  - start=1 -> DRAW next cycle; idx=0, mask=0, displays show dashes.
- DRAW:
  - Each cycle, candidate = lfsr[3:0].
  - If candidate <= 9: digit[idx] <= candidate, mask[idx] <= 1, and the display updates the next cycle.
    - If idx<4: idx++, timer=REVEAL_TICKS-1, go to GAP.
    - If idx==4: go to PUBLISH.
  - If candidate > 9: reject, stay in DRAW, retry next cycle.
- GAP:
  - Timer decrements each cycle; on 0 -> DRAW.
- PUBLISH:
  - draw_valid=1; draw_num is held stable while valid && !ack.
  - ack=1 -> HOLD; draw_valid drops the cycle after ack is sampled.
  - ack while not valid is ignored.
- HOLD:
  - Displays and draw_num retain the number.
  - start=1 -> clears displays to dashes and enters DRAW (same as IDLE).
- Simultaneous events and reset mid-operation:
  - start is ignored in DRAW, GAP and PUBLISH.
  - reset mid-draw or during PUBLISH aborts to the reset values on the next edge; a partial number is never published.
- Latency:
  - Minimum start-to-valid = 1 + 5 accepts + 4*REVEAL_TICKS cycles, plus any rejection retries.

Optional Feature:
- Macro: LOTERIA_FIXED_DRAW_EN.
- When defined: the DRAW candidate is FIXED_NUM digit[idx]. No rejection occurs, and reveal timing and handshake are unchanged. The LFSR still runs but is unused.
- When undefined: LFSR rejection sampling as above; FIXED_NUM is unused.

Decomposition:
- Shared package loteria_pkg:
  - seven-segment constants for 0-9, dash, 'P' and 'S';
  - 4-bit BCD digit typedef;
  - draw state enum (IDLE, DRAW, GAP, PUBLISH, HOLD);
  - LFSR tap constant.
- One sub-module, loteria_lfsr16: clk, reset, seed, 16-bit out; always enabled.

Test Plan:
- Reset: assert reset 2 cycles -> HEX0-HEX5=7'b0111111, LEDR=0, draw_valid=0, busy=0, draw_num=0.
- Fixed draw (LOTERIA_FIXED_DRAW_EN, REVEAL_TICKS=4): pulse start -> HEX4..HEX0 fill with 5,0,9,6,7 one digit per 5 cycles, LEDR[4:0] thermometer 00001..11111, draw_valid=1, draw_num=20'h50967.
- Random draw (macro off, seed 16'hACE1): bench LFSR model predicts the cycle and value of each accepted digit. Every accepted digit is <=9, cycles where the model nibble >9 show no mask change, and the final draw_num matches the model.
- Handshake: hold ack=0 for 100 cycles in PUBLISH -> draw_valid and draw_num constant. Pulse ack 1 cycle -> draw_valid=0 the next cycle, state HOLD, displays retained.
- Reset mid-draw: reset after 2 digits revealed -> next cycle LEDR=0, displays dashes, LFSR=16'hACE1, no draw_valid pulse.
- start while busy ignored (digit sequence unchanged). start in HOLD -> displays return to dashes and a new draw begins.
